// File: rtl/spi_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_controller
// Brief    : Mode-0 SPI initiator that serialises one 16-bit {rw, addr, wdata}
//            frame per request onto SCLK/COPI/nCS, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module spi_controller #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    localparam int                 c_CNT_W    = $clog2(DIV + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV - 1);
    localparam logic [3:0]         c_BIT_LAST = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [3:0]           r_bit;
    logic [3:0]           w_bit_nxt;
    logic [15:0]          r_shift;
    logic [15:0]          w_shift_nxt;
    logic                 r_sclk;
    logic                 w_sclk_nxt;
    logic                 r_copi;
    logic                 w_copi_nxt;
    logic                 r_ncs;
    logic                 w_ncs_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_phase_end;

    assign w_phase_end = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_sclk  <= 1'b0;
            r_copi  <= 1'b0;
            r_ncs   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_sclk  <= w_sclk_nxt;
            r_copi  <= w_copi_nxt;
            r_ncs   <= w_ncs_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and next-output values; every pin is registered so the
    // outputs carry no combinational path from the request port.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_sclk_nxt  = 1'b0;
        w_copi_nxt  = r_copi;
        w_ncs_nxt   = 1'b0;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ncs_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
                w_copi_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = ST_SETUP;
                    w_shift_nxt = {rw, addr, wdata};
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_ncs_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_copi_nxt  = rw;
                end
            end

            ST_SETUP: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                    w_sclk_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_HIGH: begin
                w_sclk_nxt = 1'b1;
                if (w_phase_end) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                    w_sclk_nxt  = 1'b0;
                    // Present the next bit on the falling edge; the last bit is held.
                    if (r_bit != c_BIT_LAST) begin
                        w_shift_nxt = {r_shift[14:0], 1'b0};
                        w_copi_nxt  = r_shift[14];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_LOW: begin
                if (w_phase_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit == c_BIT_LAST) begin
                        w_state_nxt = ST_GAP;
                        w_ncs_nxt   = 1'b1;
                        w_copi_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_HIGH;
                        w_bit_nxt   = r_bit + 1'b1;
                        w_sclk_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_GAP: begin
                w_ncs_nxt  = 1'b1;
                w_copi_nxt = 1'b0;
                if (w_phase_end) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_ncs_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
                w_copi_nxt  = 1'b0;
            end
        endcase
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sclk = r_sclk;
    assign copi = r_copi;
    assign ncs  = r_ncs;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_controller
// Brief    : Bench for spi_controller at DIV=4 (frame table, scoreboard, corner
//            sequences) and DIV=1 (single frame timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

    localparam int c_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy, done, sclk, copi, ncs;

    logic       s1_start, s1_rw;
    logic [6:0] s1_addr;
    logic [7:0] s1_wdata;
    logic       s1_busy, s1_done, s1_sclk, s1_copi, s1_ncs;

    spi_controller #(.DIV(c_DIV)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .rw    (rw),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .sclk  (sclk),
        .copi  (copi),
        .ncs   (ncs)
    );

    spi_controller #(.DIV(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (s1_start),
        .rw    (s1_rw),
        .addr  (s1_addr),
        .wdata (s1_wdata),
        .busy  (s1_busy),
        .done  (s1_done),
        .sclk  (s1_sclk),
        .copi  (s1_copi),
        .ncs   (s1_ncs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] frame;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    int          done_cnt = 0;
    int          frames_rx = 0;
    int          aborts = 0;
    int          nrise = 0;
    int          exp_done_cyc = -1;
    int          last_done_cyc = -1;
    bit          b2b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name, input int act, input int req);
        checks++;
        errors++;
        $display("FAIL %s: timeout, count=%0d required=%0d", name, act, req);
    endtask

    // Passive SPI observer: captures frames, checks bit timing and pops the scoreboard.
    task automatic monitor();
        logic        p_sclk = 1'b0, p_ncs = 1'b1, p_copi = 1'b0, p_done = 1'b0;
        int          fall_cyc = 0, ncs_rise_cyc = 0;
        logic [15:0] cap = '0;
        logic [15:0] e;
        bit          stable = 1'b1, prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (p_ncs && !ncs) begin
                fall_cyc = cyc;
                nrise    = 0;
                cap      = '0;
                stable   = 1'b1;
                if (b2b && prev_valid)
                    chk("b2b_ncs_high_gap", cyc - ncs_rise_cyc, c_DIV + 1);
            end else if (!p_ncs && !ncs) begin
                if (copi !== p_copi && !(p_sclk && !sclk))
                    stable = 1'b0;
            end
            if (!ncs && sclk && !p_sclk) begin
                nrise++;
                cap = {cap[14:0], copi};
                chk("sclk_rise_time", cyc - fall_cyc, c_DIV + (nrise - 1) * 2 * c_DIV);
            end
            if (!p_ncs && ncs) begin
                if (nrise == 16) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame: actual=%0h required=none (unexpected frame)", cap);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame", cap, e);
                    end
                    chk("ncs_low_len", cyc - fall_cyc, 33 * c_DIV);
                    chk("copi_stable", stable, 1);
                    frames_rx++;
                    exp_done_cyc = cyc + c_DIV;
                    prev_valid   = b2b;
                end else begin
                    aborts++;
                end
                ncs_rise_cyc = cyc;
            end
            if (!b2b) prev_valid = 1'b0;
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                chk("done_time", cyc, exp_done_cyc);
                chk("done_pulse_width", p_done, 0);
            end
            p_sclk = sclk;
            p_ncs  = ncs;
            p_copi = copi;
            p_done = done;
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) break;
        end
        if (done_cnt < target) timeout_fail(name, done_cnt, target);
    endtask

    task automatic wait_rise(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (nrise >= target) break;
        end
        if (nrise < target) timeout_fail(name, nrise, target);
    endtask

    // Issue one request; returns the edge count at which it was accepted.
    task automatic send(input logic r, input logic [6:0] a, input logic [7:0] d,
                        input bit push, input logic [15:0] f, output int acc);
        @(negedge clk);
        rw    = r;
        addr  = a;
        wdata = d;
        start = 1'b1;
        if (push) exp_q.push_back(f);
        @(posedge clk);
        #1;
        acc = cyc;
        chk("accept_busy_ncs", {busy, ncs}, 2'b10);
        start = 1'b0;
        rw    = 1'($urandom);
        addr  = 7'($urandom);
        wdata = 8'($urandom);
    endtask

    vec_t vecs[6];

    initial begin
        int          acc, base, base_ab;
        int          n1, busy_n, d_cyc;
        logic [15:0] cap1;
        logic        p_s;

        vecs[0] = '{1'b1, 7'h00, 8'hF0, 16'h80F0};
        vecs[1] = '{1'b0, 7'h7F, 8'hFF, 16'h7FFF};
        vecs[2] = '{1'b1, 7'h55, 8'hAA, 16'hD5AA};
        vecs[3] = '{1'b0, 7'h2A, 8'h55, 16'h2A55};
        vecs[4] = '{1'b1, 7'h01, 8'h3C, 16'h813C};
        vecs[5] = '{1'b1, 7'h00, 8'h00, 16'h8000};

        rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        s1_start = 1'b0; s1_rw = 1'b0; s1_addr = '0; s1_wdata = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_outputs", {ncs, sclk, copi, busy, done}, 5'b10000);
        chk("reset_outputs_div1", {s1_ncs, s1_sclk, s1_copi, s1_busy, s1_done}, 5'b10000);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_no_activity", {ncs, sclk, copi, busy, done}, 5'b10000);
        chk("idle_no_done", done_cnt, 0);

        // Reset asserted while idle
        #2 rst = 1'b1;
        #1 chk("reset_in_idle", {ncs, sclk, copi, busy, done}, 5'b10000);
        @(negedge clk);
        rst = 1'b0;

        // Frame table
        for (int v = 0; v < 6; v++) begin
            base = done_cnt;
            send(vecs[v].rw, vecs[v].addr, vecs[v].wdata, 1'b1, vecs[v].frame, acc);
            wait_done(base + 1, 40 * c_DIV, "vec_done");
            chk("done_latency", last_done_cyc - acc, 34 * c_DIV);
            repeat (3) @(negedge clk);
        end

        // start during a frame is ignored
        base = done_cnt;
        send(1'b1, 7'h00, 8'hAA, 1'b1, 16'h80AA, acc);
        wait_rise(5, 100, "ignore_wait_bit5");
        wdata = 8'h55;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(base + 1, 40 * c_DIV, "ignore_done");
        repeat (150) @(negedge clk);
        chk("ignore_single_done", done_cnt, base + 1);
        chk("ignore_idle_after", {busy, ncs}, 2'b01);
        chk("ignore_queue_empty", exp_q.size(), 0);

        // Back-to-back with start held high for three frames
        base = done_cnt;
        b2b  = 1'b1;
        repeat (3) exp_q.push_back(16'h813C);
        @(negedge clk);
        rw = 1'b1; addr = 7'h01; wdata = 8'h3C; start = 1'b1;
        wait_done(base + 2, 80 * c_DIV, "b2b_two_done");
        @(posedge clk);
        #1;
        chk("b2b_third_accept", {busy, ncs}, 2'b10);
        start = 1'b0;
        wait_done(base + 3, 40 * c_DIV, "b2b_third_done");
        b2b = 1'b0;
        repeat (10) @(negedge clk);
        chk("b2b_done_count", done_cnt, base + 3);
        chk("b2b_queue_empty", exp_q.size(), 0);

        // Reset after the 7th rising edge abandons the frame
        base    = done_cnt;
        base_ab = aborts;
        send(1'b1, 7'h00, 8'h99, 1'b0, 16'h0000, acc);
        wait_rise(7, 100, "abort_wait_rise7");
        #1 rst = 1'b1;
        #1 chk("abort_reset_outputs", {ncs, sclk, copi, busy, done}, 5'b10000);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_cnt, base);
        chk("abort_seen", aborts, base_ab + 1);
        send(1'b1, 7'h01, 8'h42, 1'b1, 16'h8142, acc);
        wait_done(base + 1, 40 * c_DIV, "after_abort_done");
        chk("after_abort_latency", last_done_cyc - acc, 34 * c_DIV);

        // Reset at a random point of a frame
        base    = done_cnt;
        base_ab = aborts;
        send(1'b0, 7'h33, 8'h0F, 1'b0, 16'h0000, acc);
        repeat ($urandom_range(2, 120)) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("random_reset_outputs", {ncs, sclk, copi, busy, done}, 5'b10000);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("random_reset_no_done", done_cnt, base);
        chk("random_reset_abort", aborts, base_ab + 1);

        // DIV=1 instance: frame 0x8201
        @(negedge clk);
        s1_rw = 1'b1; s1_addr = 7'h02; s1_wdata = 8'h01; s1_start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        chk("div1_accept", {s1_busy, s1_ncs}, 2'b10);
        s1_start = 1'b0;
        cap1 = '0; n1 = 0; busy_n = 0; d_cyc = -1; p_s = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (s1_busy) busy_n++;
            if (!s1_ncs && s1_sclk && !p_s) begin
                n1++;
                cap1 = {cap1[14:0], s1_copi};
                chk("div1_rise_time", cyc - acc, 1 + (n1 - 1) * 2);
            end
            if (s1_done && d_cyc < 0) d_cyc = cyc;
            p_s = s1_sclk;
        end
        chk("div1_frame", cap1, 16'h8201);
        chk("div1_rise_count", n1, 16);
        chk("div1_busy_cycles", busy_n, 34);
        chk("div1_done_latency", d_cyc - acc, 34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
